// File: rtl/aurora_seq_pkg.sv
// Shared state encoding and widths for the Aurora link sequencer.
package aurora_seq_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PMA       = 3'd1,
        RST       = 3'd2,
        WAIT_LANE = 3'd3,
        WAIT_CHAN = 3'd4,
        UP        = 3'd5,
        BACKOFF   = 3'd6
    } state_t;

endpackage

// File: rtl/aurora_sync_bit.sv
// Two-flop synchroniser for a single level signal crossing into init_clk.
module aurora_sync_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/aurora_link_sequencer.sv
// Bring-up and recovery sequencer for a single-MGT Aurora wrapper: orders pma_init and
// reset, waits for lane/channel with timeouts, and relinks after a backoff on faults.
module aurora_link_sequencer
    import aurora_seq_pkg::*;
#(
    parameter int TIMER_W         = 24,
    parameter int PMA_INIT_CYCLES = 256,
    parameter int RESET_CYCLES    = 64,
    parameter int LANE_TIMEOUT    = 1000000,
    parameter int CHAN_TIMEOUT    = 1000000,
    parameter int BACKOFF_CYCLES  = 4096,
    parameter int SOFT_WIN_CYCLES = 65536,
    parameter int SOFT_ERR_LIMIT  = 16
) (
    input  logic               init_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               force_relink,
    input  logic               dcm_not_locked,
    input  logic               lane_up,
    input  logic               channel_up,
    input  logic               hard_error,
    input  logic               soft_error,
    output logic               pma_init,
    output logic               aurora_reset,
    output logic               link_ok,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retry_count,
    output logic               timeout_flag,
    output logic               link_drop
);

    localparam int WIN_W = (SOFT_WIN_CYCLES > 2) ? $clog2(SOFT_WIN_CYCLES) : 1;
    localparam int CNT_W = $clog2(SOFT_ERR_LIMIT + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SOFT_WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(SOFT_ERR_LIMIT);

    logic w_dcm_s, w_lane_s, w_chan_s, w_hard_s, w_soft_s;

    aurora_sync_bit u_sync_dcm  (.i_clk(init_clk), .i_rst(reset), .i_d(dcm_not_locked), .o_q(w_dcm_s));
    aurora_sync_bit u_sync_lane (.i_clk(init_clk), .i_rst(reset), .i_d(lane_up),        .o_q(w_lane_s));
    aurora_sync_bit u_sync_chan (.i_clk(init_clk), .i_rst(reset), .i_d(channel_up),     .o_q(w_chan_s));
    aurora_sync_bit u_sync_hard (.i_clk(init_clk), .i_rst(reset), .i_d(hard_error),     .o_q(w_hard_s));
    aurora_sync_bit u_sync_soft (.i_clk(init_clk), .i_rst(reset), .i_d(soft_error),     .o_q(w_soft_s));

    state_t               r_state;
    state_t               w_next;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_load;
    logic                 w_timer_zero;
    logic                 w_up_exit;
    logic                 w_timeout;
    logic [WIN_W-1:0]     r_win;
    logic [CNT_W-1:0]     r_soft_cnt;
    logic                 r_soft_prev;
    logic                 w_soft_edge;
    logic                 w_soft_trip;
    logic                 r_link_drop;
    logic                 r_timeout;
    logic [RETRY_W-1:0]   r_retry;

    assign w_timer_zero = (r_timer == '0);
    assign w_soft_edge  = w_soft_s & ~r_soft_prev;
    assign w_soft_trip  = (r_soft_cnt >= CNT_LIM);

    always_comb begin
        w_next    = r_state;
        w_up_exit = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:      if (enable && !w_dcm_s) w_next = PMA;
            PMA:       if (w_timer_zero) w_next = RST;
            RST:       if (w_timer_zero) w_next = WAIT_LANE;
            WAIT_LANE: begin
                if (w_lane_s) begin
                    w_next = WAIT_CHAN;
                end else if (w_timer_zero) begin
                    w_next    = BACKOFF;
                    w_timeout = 1'b1;
                end
            end
            WAIT_CHAN: begin
                if (w_chan_s) begin
                    w_next = UP;
                end else if (!w_lane_s || w_timer_zero) begin
                    w_next    = BACKOFF;
                    w_timeout = w_timer_zero;
                end
            end
            UP: begin
                if (w_hard_s || !w_chan_s || w_soft_trip || force_relink) begin
                    w_next    = BACKOFF;
                    w_up_exit = 1'b1;
                end
            end
            BACKOFF:   if (w_timer_zero) w_next = PMA;
            default:   w_next = IDLE;
        endcase
        // Loss of enable or clock lock parks the link without counting as a drop.
        if (!enable || w_dcm_s) begin
            w_next    = IDLE;
            w_up_exit = 1'b0;
            w_timeout = 1'b0;
        end
    end

    always_comb begin
        w_timer_load = '0;
        case (w_next)
            PMA:       w_timer_load = TIMER_W'(PMA_INIT_CYCLES - 1);
            RST:       w_timer_load = TIMER_W'(RESET_CYCLES - 1);
            WAIT_LANE: w_timer_load = TIMER_W'(LANE_TIMEOUT - 1);
            WAIT_CHAN: w_timer_load = TIMER_W'(CHAN_TIMEOUT - 1);
            BACKOFF:   w_timer_load = TIMER_W'(BACKOFF_CYCLES - 1);
            default:   w_timer_load = '0;
        endcase
    end

    always_ff @(posedge init_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_link_drop <= 1'b0;
            r_timeout   <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_next;
            r_link_drop <= w_up_exit;
            if (w_next != r_state)
                r_timer <= w_timer_load;
            else if (!w_timer_zero)
                r_timer <= r_timer - TIMER_W'(1);
            if (w_timeout)
                r_timeout <= 1'b1;
            if (w_up_exit && (r_retry != '1))
                r_retry <= r_retry + RETRY_W'(1);
        end
    end

    // Soft-error window restarts at every UP entry; an edge on the wrap cycle opens the new window.
    always_ff @(posedge init_clk) begin
        if (reset) begin
            r_soft_prev <= 1'b0;
        end else begin
            r_soft_prev <= w_soft_s;
        end
        if (reset || (r_state != UP)) begin
            r_win      <= '0;
            r_soft_cnt <= '0;
        end else if (r_win == WIN_LAST) begin
            r_win      <= '0;
            r_soft_cnt <= w_soft_edge ? CNT_W'(1) : '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
            if (w_soft_edge && !w_soft_trip)
                r_soft_cnt <= r_soft_cnt + CNT_W'(1);
        end
    end

    assign pma_init     = (r_state == IDLE) || (r_state == PMA);
    assign aurora_reset = (r_state == IDLE) || (r_state == PMA) ||
                          (r_state == RST)  || (r_state == BACKOFF);
    assign link_ok      = (r_state == UP);
    assign state_o      = r_state;
    assign retry_count  = r_retry;
    assign timeout_flag = r_timeout;
    assign link_drop    = r_link_drop;

endmodule
